// File: rtl/dcache_controller.sv
// Miss/refill sequencer for a 2-way, 16-set, 32-byte-line data cache SRAM.
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss counter outputs.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    input  logic         sram_hit_i,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;
    localparam logic [1:0] REFILL    = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [22:0]  miss_tag;
    logic [3:0]   miss_index;
    logic [22:0]  victim_tag;
    logic [255:0] victim_line;
    logic [255:0] fill_line;
    logic [7:0]   word_sel;
    logic [255:0] merged_line;
    logic         lookup_hit;
    logic         lookup_miss;
    logic         victim_dirty;

    assign word_sel     = {cpu_addr_i[4:2], 5'b0};
    assign lookup_hit   = (state == IDLE) && cpu_req_i && sram_hit_i;
    assign lookup_miss  = (state == IDLE) && cpu_req_i && !sram_hit_i;
    assign victim_dirty = sram_tag_i[24] && sram_tag_i[23];
    assign cpu_stall_o  = (state != IDLE) || (cpu_req_i && !sram_hit_i);

    always_comb begin
        merged_line = sram_data_i;
        merged_line[word_sel +: 32] = cpu_data_i;
    end

    always_comb begin
        state_next    = state;
        cpu_data_o    = 32'd0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = 4'd0;
        sram_tag_o    = 25'd0;
        sram_data_o   = 256'd0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = 32'd0;
        mem_data_o    = 256'd0;
        case (state)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                sram_addr_o   = cpu_addr_i[8:5];
                sram_tag_o    = {1'b1, cpu_we_i, cpu_addr_i[31:9]};
                if (lookup_hit) begin
                    cpu_data_o = sram_data_i[word_sel +: 32];
                    if (cpu_we_i) begin
                        sram_write_o = 1'b1;
                        sram_data_o  = merged_line;
                    end
                end else if (lookup_miss) begin
                    state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {victim_tag, miss_index, 5'b0};
                mem_data_o = victim_line;
                if (mem_ack_i) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_tag, miss_index, 5'b0};
                if (mem_ack_i) state_next = REFILL;
            end
            default: begin
                // Install the clean line; the CPU's re-lookup in IDLE then hits.
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_addr_o   = miss_index;
                sram_tag_o    = {1'b1, 1'b0, miss_tag};
                sram_data_o   = fill_line;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            miss_tag    <= 23'd0;
            miss_index  <= 4'd0;
            victim_tag  <= 23'd0;
            victim_line <= 256'd0;
            fill_line   <= 256'd0;
        end else begin
            state <= state_next;
            if (lookup_miss) begin
                miss_tag    <= cpu_addr_i[31:9];
                miss_index  <= cpu_addr_i[8:5];
                victim_tag  <= sram_tag_i[22:0];
                victim_line <= sram_data_i;
            end
            if (state == ALLOCATE && mem_ack_i) fill_line <= mem_data_i;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic relookup;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The first IDLE cycle after REFILL is the miss's own re-lookup, not a new hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            relookup   <= 1'b0;
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            relookup <= (state == REFILL);
            if (lookup_hit && !relookup) hit_cnt_o <= sat_inc(hit_cnt_o);
            if (lookup_miss) miss_cnt_o <= sat_inc(miss_cnt_o);
        end
    end
`endif

endmodule
